// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - sequencer driving a shared 8-bit add/sub unit for ADD/SUB/MUL/DIV
// Optional restoring divider enabled by ALU_SEQ_DIV_EN; otherwise DIV reports err.
module alu_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       ready,
  output logic       done,
  output logic [7:0] res_hi,
  output logic [7:0] res_lo,
  output logic       carry,
  output logic       overflow,
  output logic       negative,
  output logic       zero,
  output logic       err,
  output logic [7:0] alu_x,
  output logic [7:0] alu_y,
  output logic       alu_sub,
  output logic       alu_en,
  input  logic [7:0] alu_z,
  input  logic       alu_c8,
  input  logic       alu_ovf,
  input  logic       alu_neg,
  input  logic       alu_zero
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  acc_q, acc_d;   // MUL: A, DIV: R
  logic [7:0]  qr_q, qr_d;     // MUL/DIV: Q
  logic [7:0]  m_q, m_d;       // MUL: M, DIV: D; ADD/SUB: b
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic        carry_q, carry_d, ovf_q, ovf_d, neg_q, neg_d, zero_q, zero_d, err_q, err_d;
  logic [15:0] mul_next;
  logic        last_iter;
`ifdef ALU_SEQ_DIV_EN
  logic [7:0]  div_s;
  logic        div_ok;
  logic [7:0]  div_r;
  logic [7:0]  div_q;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    qr_d     = qr_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    err_d    = err_q;
    alu_x    = 8'd0;
    alu_y    = 8'd0;
    alu_sub  = 1'b0;
    alu_en   = 1'b0;
    // A:Q shifted right with the adder carry entering at the top
    mul_next  = {alu_c8, alu_z, qr_q[7:1]};
    last_iter = (cnt_q == 3'd7);
`ifdef ALU_SEQ_DIV_EN
    div_s  = {acc_q[6:0], qr_q[7]};
    div_ok = acc_q[7] | alu_c8;
    div_r  = div_ok ? alu_z : div_s;
    div_q  = {qr_q[6:0], div_ok};
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_EXEC;
          op_d    = op;
          acc_d   = 8'd0;
          qr_d    = a;
          m_d     = b;
          cnt_d   = 3'd0;
        end
      end
      ST_EXEC: begin
        if (op_q == OP_ADD || op_q == OP_SUB) begin
          alu_en   = 1'b1;
          alu_x    = qr_q;
          alu_y    = m_q;
          alu_sub  = op_q[0];
          state_d  = ST_DONE;
          res_hi_d = 8'd0;
          res_lo_d = alu_z;
          carry_d  = alu_c8;
          ovf_d    = alu_ovf;
          neg_d    = alu_neg;
          zero_d   = alu_zero;
          err_d    = 1'b0;
        end else if (op_q == OP_MUL) begin
          alu_en = 1'b1;
          alu_x  = acc_q;
          alu_y  = qr_q[0] ? m_q : 8'd0;
          acc_d  = mul_next[15:8];
          qr_d   = mul_next[7:0];
          cnt_d  = cnt_q + 3'd1;
          if (last_iter) begin
            state_d  = ST_DONE;
            res_hi_d = mul_next[15:8];
            res_lo_d = mul_next[7:0];
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
            neg_d    = 1'b0;
            zero_d   = (mul_next == 16'd0);
            err_d    = 1'b0;
          end
        end else begin
`ifdef ALU_SEQ_DIV_EN
          if (m_q == 8'd0) begin
            state_d  = ST_DONE;
            res_hi_d = qr_q;
            res_lo_d = 8'hFF;
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
            neg_d    = 1'b0;
            zero_d   = 1'b0;
            err_d    = 1'b1;
          end else begin
            alu_en  = 1'b1;
            alu_x   = div_s;
            alu_y   = m_q;
            alu_sub = 1'b1;
            acc_d   = div_r;
            qr_d    = div_q;
            cnt_d   = cnt_q + 3'd1;
            if (last_iter) begin
              state_d  = ST_DONE;
              res_hi_d = div_r;
              res_lo_d = div_q;
              carry_d  = 1'b0;
              ovf_d    = 1'b0;
              neg_d    = 1'b0;
              zero_d   = (div_q == 8'd0);
              err_d    = 1'b0;
            end
          end
`else
          state_d  = ST_DONE;
          res_hi_d = 8'd0;
          res_lo_d = 8'd0;
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
          neg_d    = 1'b0;
          zero_d   = 1'b0;
          err_d    = 1'b1;
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= 2'd0;
      acc_q    <= 8'd0;
      qr_q     <= 8'd0;
      m_q      <= 8'd0;
      cnt_q    <= 3'd0;
      res_hi_q <= 8'd0;
      res_lo_q <= 8'd0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      qr_q     <= qr_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign ready    = (state_q == ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign res_hi   = res_hi_q;
  assign res_lo   = res_lo_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign negative = neg_q;
  assign zero     = zero_q;
  assign err      = err_q;

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle sequencer that owns the shared 8-bit carry-lookahead add/sub unit and uses it to execute ADD, SUB, unsigned MUL (shift-add) and unsigned DIV (restoring). It sits between the ALU command interface and the adder:
- It latches operands on a start handshake.
- It drives the adder's operand, select and enable inputs every cycle.
- It registers a 16-bit result plus flags, and pulses `done` when the result is valid.

## Interface
- Parameters: none. Datapath width is fixed at 8 bits to match the adder.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: command request; accepted only when `ready`=1.
- `op` in 2: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
- `a`, `b` in 8 each: operands (DIV: a=dividend, b=divisor).
- `ready` out 1: high only in IDLE.
- `done` out 1: one-cycle pulse; result and flags valid.
- `res_hi`, `res_lo` out 8 each: result (MUL: product hi/lo; DIV: remainder/quotient; ADD/SUB: hi=0, lo=sum).
- `carry`, `overflow`, `negative`, `zero`, `err` out 1 each: registered flags.
- `alu_x`, `alu_y` out 8 each: adder operands.
- `alu_sub` out 1: adder select (1=subtract).
- `alu_en` out 1: adder start/enable.
- `alu_z` in 8: adder sum.
- `alu_c8`, `alu_ovf`, `alu_neg`, `alu_zero` in 1 each: adder carry-out and flags.

## Operation
- States: IDLE, EXEC, DONE.
  - IDLE→EXEC on `start`. On accept, `op`/`a`/`b` are captured into internal registers; later input changes are ignored.
  - EXEC→DONE after N iterations: ADD/SUB N=1; MUL/DIV N=8. A 3-bit counter counts iterations.
  - DONE→IDLE unconditionally.
- `start` while not IDLE is ignored; no queuing.
- `alu_en`=1 only in EXEC. Outside EXEC, `alu_x`/`alu_y`/`alu_sub` are 0.
- ADD/SUB:
  - Drive x=a, y=b, sub=op[0].
  - Register lo=alu_z, carry=alu_c8, overflow/negative/zero from the adder.
- MUL (regs C,A,Q,M; A=0, Q=a, M=b):
  - Each iteration: drive x=A, y=(Q[0]?M:0), sub=0.
  - Then {C,A,Q} ← {alu_c8,alu_z,Q}>>1.
  - After 8 iterations: hi=A, lo=Q.
  - carry=overflow=negative=0; zero=(product==0).
- DIV (regs R,Q,D; R=0, Q=a, D=b):
  - Each iteration: {m,S}={R,Q[7]}<<… i.e. m=R[7], S={R[6:0],Q[7]}; drive x=S, y=D, sub=1.
  - ok=m|alu_c8. R ← ok?alu_z:S. Q ← {Q[6:0],ok}.
  - Result: hi=R, lo=Q. Flags: zero=(quotient==0), others 0.
- Divide by zero (b=0): EXEC lasts 1 cycle and the adder is not used (`alu_en`=0). Result: lo=8'hFF, hi=a, err=1.
- `err`=0 for every other operation.
- Results and flags hold their values from DONE until the next DONE.

## Timing
- Reset values:
  - State=IDLE, `ready`=1.
  - `done`, `res_hi`, `res_lo`, all flags, `alu_*` outputs = 0.
- Cycle numbering: `start` sampled high at the end of cycle 0.
  - ADD/SUB: EXEC cycle 1; `done` cycle 2.
  - MUL/DIV: EXEC cycles 1–8; `done` cycle 9.
  - DIV-by-zero: `done` cycle 2.
- `ready` is low from cycle 1 through the `done` cycle. The earliest next accept is the cycle after `done`.
- The adder is combinational. Its outputs are sampled at the end of each EXEC cycle, and the result registers update on the same edge that enters DONE.
- `rst_n` low mid-operation aborts immediately:
  - All outputs return to reset values.
  - No `done` is issued for the aborted command.

## Configuration
- `ALU_SEQ_DIV_EN` defined: DIV is implemented as described above.
- `ALU_SEQ_DIV_EN` undefined: op=11 takes the 1-cycle path and finishes with `done` at cycle 2. Result: res_hi=res_lo=0, err=1, other flags 0, `alu_en` never asserted. The DIV datapath is absent.

## Test plan
- ADD a=127, b=1 → `done` cycle 2; lo=8'h80, overflow=1, negative=1, carry=0.
- SUB a=100, b=100 → lo=0, zero=1, carry=1; `alu_sub`=1 during EXEC only.
- MUL a=255, b=255 → `done` cycle 9; hi=8'hFE, lo=8'h01. MUL a=0, b=77 → product 0, zero=1.
- DIV a=200, b=7 → `done` cycle 9; lo=28, hi=4. DIV a=9, b=0 → `done` cycle 2; err=1, lo=8'hFF, hi=9.
- `start` pulsed during a MUL, with `a`/`b` changed mid-op → ignored; the original product is unchanged. A back-to-back `start` in the cycle after `done` is accepted.
- `rst_n` low at cycle 4 of a DIV → all outputs 0 asynchronously, `ready`=1 after release, no `done`. Without `ALU_SEQ_DIV_EN`: DIV → err=1, `done` at cycle 2.
